// File: rtl/pt_check.sv
// pt_check: scans the length-prefixed plaintext in pt_mem and reports whether every message byte is printable.
// Optional macro PT_CHECK_ERRADDR_EN adds bad_addr, the address of the first failing byte (0 on a pass).
module pt_check #(
  parameter logic [7:0] LO_CHAR = 8'h20,
  parameter logic [7:0] HI_CHAR = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       rdy,
  output logic       valid,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata
`ifdef PT_CHECK_ERRADDR_EN
  ,
  output logic [7:0] bad_addr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_SCAN, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic       r_valid;
  logic       w_byte_ok;
  logic       w_last;

  // r_idx is the address whose data is arriving on pt_rddata this cycle
  assign w_byte_ok = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);
  assign w_last    = (r_idx == r_len);
  assign valid     = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_next = enable ? S_LEN : S_IDLE;
      S_LEN:          w_state_next = (pt_rddata == 8'd0) ? S_DONE : S_SCAN;
      S_SCAN: begin
        if (!w_byte_ok || w_last) begin
          w_state_next = S_DONE;
        end
      end
      default:        w_state_next = S_IDLE;
    endcase
  end

  // The next address is chosen combinationally so a failing or final byte never triggers a further read
  always_comb begin
    rdy     = 1'b0;
    pt_addr = 8'd0;
    case (r_state)
      S_IDLE, S_DONE: rdy = 1'b1;
      S_LEN:          pt_addr = (pt_rddata != 8'd0) ? 8'd1 : 8'd0;
      S_SCAN:         pt_addr = (w_byte_ok && !w_last) ? r_idx + 8'd1 : r_idx;
      default:        pt_addr = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= 8'd0;
      r_idx   <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (enable) begin
            r_valid <= 1'b0;
          end
        end
        S_LEN: begin
          r_len <= pt_rddata;
          r_idx <= 8'd1;
          if (pt_rddata == 8'd0) begin
            r_valid <= 1'b1;
          end
        end
        S_SCAN: begin
          r_idx <= pt_addr;
          if (w_byte_ok && w_last) begin
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PT_CHECK_ERRADDR_EN
  logic [7:0] r_bad_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad_addr <= 8'd0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && enable) begin
      r_bad_addr <= 8'd0;
    end else if (r_state == S_SCAN && !w_byte_ok) begin
      r_bad_addr <= r_idx;
    end
  end

  assign bad_addr = r_bad_addr;
`endif

endmodule

// File: tb/tb_pt_check.sv
// tb_pt_check: randomized and directed scans of pt_check against a scoreboard of expected results.
// Builds with or without PT_CHECK_ERRADDR_EN.
`timescale 1ns/1ps
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rdy;
  logic       valid;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
`ifdef PT_CHECK_ERRADDR_EN
  logic [7:0] bad_addr;
`endif

  always #5 clk = ~clk;

  pt_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rdy       (rdy),
    .valid     (valid),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata)
`ifdef PT_CHECK_ERRADDR_EN
    ,
    .bad_addr  (bad_addr)
`endif
  );

  logic [7:0] mem [256];
  logic [7:0] img [$];

  always @(posedge clk) pt_rddata <= mem[pt_addr];

  typedef struct {
    int         len;
    logic       v;
    int         lat;
    logic [7:0] bad;
    logic [7:0] maxa;
  } exp_t;

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   running = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference: first out-of-range byte decides the result, reads stop there
  function automatic exp_t model();
    exp_t e;
    int   l;
    l      = int'(mem[0]);
    e.len  = l;
    e.v    = 1'b1;
    e.bad  = 8'd0;
    e.maxa = 8'(l);
    e.lat  = l + 2;
    for (int k = 1; k <= l; k++) begin
      if (mem[k] < 8'h20 || mem[k] > 8'h7E) begin
        e.v    = 1'b0;
        e.bad  = 8'(k);
        e.maxa = 8'(k);
        e.lat  = k + 2;
        break;
      end
    end
    return e;
  endfunction

  function automatic void img_str(input logic [7:0] len, input string s);
    img.delete();
    img.push_back(len);
    for (int i = 0; i < s.len(); i++) img.push_back(s[i]);
  endfunction

  function automatic void apply_img();
    for (int i = 0; i < 256; i++) mem[i] = (i < img.size()) ? img[i] : 8'h01;
  endfunction

  // Monitor: samples on the falling edge, times each run and checks it against the scoreboard
  initial begin
    int         cyc;
    logic [7:0] maxa;
    exp_t       e;
    cyc  = 0;
    maxa = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        running = 0;
      end else begin
        if (running) begin
          cyc++;
          if (pt_addr > maxa) maxa = pt_addr;
          if (cyc == 1) begin
            check("cyc1_rdy", int'(rdy), 0);
            check("cyc1_valid", int'(valid), 0);
`ifdef PT_CHECK_ERRADDR_EN
            check("cyc1_bad_addr", int'(bad_addr), 0);
`endif
          end
          if (rdy) begin
            running = 0;
            if (sb_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_run: got a completed run after %0d cycles, expected none", cyc);
            end else begin
              e = sb_q.pop_front();
              $display("run L=%0d valid=%0d cycles=%0d max_addr=%0d", e.len, valid, cyc, maxa);
              check("latency", cyc, e.lat);
              check("valid", int'(valid), int'(e.v));
              check("max_addr", int'(maxa), int'(e.maxa));
`ifdef PT_CHECK_ERRADDR_EN
              check("bad_addr", int'(bad_addr), int'(e.bad));
`endif
            end
          end else if (cyc > 400) begin
            running = 0;
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: rdy=%0d after %0d cycles, expected 1", rdy, cyc);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
          end
        end
        if (!running && enable && rdy) begin
          running = 1;
          cyc     = 0;
          maxa    = pt_addr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!rdy && n < 600) begin
      tick();
      n++;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_rdy: rdy=%0d after %0d cycles, expected 1", rdy, n);
    end
  endtask

  // Memory is swapped only while rdy=1, after the previous run's last read has been captured
  task automatic start_run(input int gap);
    wait_rdy();
    repeat (gap) tick();
    apply_img();
    sb_q.push_back(model());
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  initial begin
    int len;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1;
    check("rst_rdy", int'(rdy), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_pt_addr", int'(pt_addr), 0);
`ifdef PT_CHECK_ERRADDR_EN
    check("rst_bad_addr", int'(bad_addr), 0);
`endif
    #22 rst_n = 1'b1;
    tick();

    img_str(8'h05, "Hello");
    start_run(2);
    img_str(8'h03, "A");
    img.push_back(8'h0A);
    img.push_back(8'h42);
    start_run(1);
    img_str(8'h00, "");
    start_run(1);
    img_str(8'h02, "");
    img.push_back(8'h20);
    img.push_back(8'h7E);
    start_run(1);
    img_str(8'h01, "");
    img.push_back(8'h7F);
    start_run(1);
    img_str(8'h01, "");
    img.push_back(8'h1F);
    start_run(1);
    img_str(8'hFF, "");
    for (int i = 0; i < 255; i++) img.push_back(8'h7A);
    start_run(1);

    // Reset during the scan of "Hello": must clear outputs without a clock edge
    img_str(8'h05, "Hello");
    start_run(1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("async_rst_rdy", int'(rdy), 1);
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_pt_addr", int'(pt_addr), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // enable held for 10 cycles: one run, then a second in the cycle rdy returns
    sb_q.push_back(model());
    sb_q.push_back(model());
    enable = 1'b1;
    repeat (10) tick();
    enable = 1'b0;

    // Back-to-back: pass then fail, second enable in the first rdy=1 cycle
    img_str(8'h05, "Hello");
    start_run(1);
    img_str(8'h03, "A");
    img.push_back(8'h0A);
    img.push_back(8'h42);
    start_run(0);

    for (int r = 0; r < 30; r++) begin
      len = int'($urandom_range(0, 40));
      img.delete();
      img.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 29) == 0) img.push_back(8'($urandom_range(0, 255)));
        else img.push_back(8'($urandom_range(32, 126)));
      end
      start_run(int'($urandom_range(0, 2)));
    end

    wait_rdy();
    for (int n = 0; n < 50 && (sb_q.size() != 0 || running); n++) tick();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d runs still pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
